// File: rtl/sd_cmd_rsp_rx.sv
// SD CMD-line response receiver for 48-bit R1/R3/R6/R7 frames.
// Hunts for the start bit under an NCR timeout, shifts the frame in, and checks CRC7 and framing.
module sd_cmd_rsp_rx #(
  parameter int TIMEOUT = 64,
  parameter int TO_BITS = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        cmd_in,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        crc_err,
  output logic        frame_err,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_RECV  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_FIN   = 3'd4;

  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(TIMEOUT);

  logic [2:0]         state_q, state_d;
  logic [47:0]        shift_q, shift_d;
  logic [5:0]         bitcnt_q, bitcnt_d;
  logic [TO_BITS-1:0] tocnt_q, tocnt_d, tocnt_inc;
  logic [6:0]         crc_q, crc_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               timeout_q, timeout_d;
  logic               crc_err_q, crc_err_d;
  logic               frame_err_q, frame_err_d;
  logic [5:0]         index_q, index_d;
  logic [31:0]        arg_q, arg_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign tocnt_inc = tocnt_q + TO_BITS'(1);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    tocnt_d     = tocnt_q;
    crc_d       = crc_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    timeout_d   = 1'b0;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;
    index_d     = index_q;
    arg_d       = arg_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_WAIT;
          busy_d      = 1'b1;
          tocnt_d     = '0;
          crc_d       = '0;
          bitcnt_d    = '0;
          shift_d     = '0;
          crc_err_d   = 1'b0;
          frame_err_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (tick) begin
          if (!cmd_in) begin
            state_d  = ST_RECV;
            shift_d  = {shift_q[46:0], cmd_in};
            bitcnt_d = 6'd1;
            crc_d    = crc7_step(crc_q, cmd_in);
          end else if (tocnt_q != TO_LIMIT) begin
            tocnt_d = tocnt_inc;
            if (tocnt_inc == TO_LIMIT) begin
              state_d   = ST_IDLE;
              timeout_d = 1'b1;
              busy_d    = 1'b0;
            end
          end
        end
      end
      ST_RECV: begin
        if (tick) begin
          shift_d  = {shift_q[46:0], cmd_in};
          bitcnt_d = bitcnt_q + 6'd1;
          // Only the first 40 bits (start bit through argument) are CRC-protected.
          if (bitcnt_q < 6'd40) crc_d = crc7_step(crc_q, cmd_in);
          if (bitcnt_q == 6'd47) state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        index_d     = shift_q[45:40];
        arg_d       = shift_q[39:8];
        crc_err_d   = (crc_q != shift_q[7:1]);
        frame_err_d = shift_q[47] | shift_q[46] | ~shift_q[0];
        state_d     = ST_FIN;
      end
      ST_FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bitcnt_q    <= '0;
      tocnt_q     <= '0;
      crc_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      index_q     <= '0;
      arg_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bitcnt_q    <= bitcnt_d;
      tocnt_q     <= tocnt_d;
      crc_q       <= crc_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
      index_q     <= index_d;
      arg_q       <= arg_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign crc_err    = crc_err_q;
  assign frame_err  = frame_err_q;
  assign resp_index = index_q;
  assign resp_arg   = arg_q;

endmodule
